// File: rtl/axi_pkg.sv
// Shared AXI4 constants and helpers for the read merger.
// Holds burst/cache/resp encodings and the beat-size calculation.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DFLT = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant starting from a rotating pointer.
// Pointer moves to winner+1 whenever a grant is issued.
module rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;
    logic [N-1:0]  grant;
    logic          found;

    // search requests starting at the pointer, first hit wins
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                grant[(int'(ptr_q) + k) % N] = 1'b1;
                gidx = PW'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign grant_o = en_i ? grant : '0;

    // advance pointer past the winner on an issued grant
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

    // pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_rd_mux_rr.sv
// N-client AXI4 read merger: round-robin AR arbitration into one AR
// register, per-channel outstanding limit, R beats routed back by RID.
module axi_rd_mux_rr
    import axi_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 8,
    parameter int USER_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        s_arvalid,
    output logic [NUM_CH-1:0]        s_arready,
    input  logic [NUM_CH*ADDR_W-1:0] s_araddr,
    input  logic [NUM_CH*8-1:0]      s_arlen,
    output logic [NUM_CH-1:0]        s_rvalid,
    input  logic [NUM_CH-1:0]        s_rready,
    output logic [DATA_W-1:0]        s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rlast,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [ID_W-1:0]          m_axi_arid,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic [2:0]               m_axi_arprot,
    output logic [3:0]               m_axi_arcache,
    output logic [USER_W-1:0]        m_axi_aruser,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    input  logic [DATA_W-1:0]        m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic [ID_W-1:0]          m_axi_rid,
    output logic                     idle,
    output logic                     err
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic                      arvalid_q;
    logic [ADDR_W-1:0]         araddr_q;
    logic [7:0]                arlen_q;
    logic [ID_W-1:0]           arid_q;
    logic                      err_q;

    logic                      loadable, ar_hs, r_hs, rid_ok;
    logic [NUM_CH-1:0]         elig, grant;
    logic [ADDR_W-1:0]         gaddr;
    logic [7:0]                glen;
    logic [ID_W-1:0]           gid;
    logic                      rready_sel;

    assign ar_hs    = arvalid_q & m_axi_arready;
    assign loadable = ~arvalid_q | m_axi_arready;
    assign r_hs     = m_axi_rvalid & m_axi_rready;
    assign rid_ok   = int'(m_axi_rid) < NUM_CH;

    // eligibility counts the AR still sitting in the register
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = s_arvalid[i] &&
                (int'(cnt_q[i]) +
                 int'(arvalid_q && arid_q == ID_W'(i)) < MAX_OUTST);
        end
    end

    rr_arb #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (elig),
        .en_i    (loadable),
        .grant_o (grant)
    );

    assign s_arready = grant;

    // select payload of the granted channel
    always_comb begin
        gaddr = '0;
        glen  = '0;
        gid   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gaddr = s_araddr[i*ADDR_W +: ADDR_W];
                glen  = s_arlen[i*8 +: 8];
                gid   = ID_W'(i);
            end
        end
    end

    // AR register: load on grant, clear after handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
        end else if (|grant) begin
            arvalid_q <= 1'b1;
            araddr_q  <= gaddr;
            arlen_q   <= glen;
            arid_q    <= gid;
        end else if (ar_hs) begin
            arvalid_q <= 1'b0;
        end
    end

    // R demux by RID; unknown IDs are drained
    always_comb begin
        s_rvalid   = '0;
        rready_sel = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_axi_rid == ID_W'(i)) begin
                s_rvalid[i] = m_axi_rvalid;
                rready_sel  = s_rready[i];
            end
        end
    end

    // outstanding-burst counters
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case ({ar_hs && arid_q == ID_W'(i),
                          r_hs && m_axi_rlast &&
                          m_axi_rid == ID_W'(i) && cnt_q[i] != '0})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (r_hs && (!rid_ok || m_axi_rresp != AXI_RESP_OKAY)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_arsize  = axi_size(DATA_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arcache = AXI_CACHE_DFLT;
    assign m_axi_aruser  = '0;

    assign m_axi_rready = rready_sel;
    assign s_rdata      = m_axi_rdata;
    assign s_rresp      = m_axi_rresp;
    assign s_rlast      = m_axi_rlast;

    assign idle = ~arvalid_q && (cnt_q == '0);
    assign err  = err_q;

endmodule

// File: tb/tb_axi_rd_mux_rr.sv
// Directed bench for axi_rd_mux_rr: arbitration, stall, limits,
// R routing and error flagging with hand-computed expectations.
module tb_axi_rd_mux_rr;

    localparam int NC = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   s_arvalid;
    logic [NC-1:0]   s_arready;
    logic [NC*AW-1:0] s_araddr;
    logic [NC*8-1:0] s_arlen;
    logic [NC-1:0]   s_rvalid;
    logic [NC-1:0]   s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [IW-1:0]   m_axi_arid;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic [2:0]      m_axi_arprot;
    logic [3:0]      m_axi_arcache;
    logic [0:0]      m_axi_aruser;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic [IW-1:0]   m_axi_rid;
    logic            idle;
    logic            err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_rd_mux_rr #(
        .NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW),
        .ID_W(IW), .MAX_OUTST(2), .USER_W(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arid(m_axi_arid), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
        .m_axi_arcache(m_axi_arcache), .m_axi_aruser(m_axi_aruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
        .idle(idle), .err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        s_arvalid     = '0;
        s_araddr      = {64'h3000, 64'h2000, 64'h1000};
        s_arlen       = {8'd3, 8'd2, 8'd1};
        s_rready      = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_arvalid = '0;
        m_axi_rvalid = 1'b0;
        #2;
        checks++;
        if (m_axi_arvalid !== 1'b0 || s_arready !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid arvalid=%b s_arready=%b want 0/000",
                     m_axi_arvalid, s_arready);
        end
        checks++;
        if (idle !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle idle=%b err=%b want 1/0", idle, err);
        end
        checks++;
        if (m_axi_araddr !== 64'h0 || m_axi_arlen !== 8'h0 ||
            m_axi_arid !== 4'h0) begin
            errors++;
            $display("FAIL reset_payload addr=%h len=%h id=%h want 0",
                     m_axi_araddr, m_axi_arlen, m_axi_arid);
        end
        checks++;
        if (m_axi_arsize !== 3'd6 || m_axi_arburst !== 2'b01 ||
            m_axi_arcache !== 4'b0011 || m_axi_arprot !== 3'b000 ||
            m_axi_aruser !== 1'b0) begin
            errors++;
            $display("FAIL consts size=%0d burst=%b cache=%b prot=%b user=%b",
                     m_axi_arsize, m_axi_arburst, m_axi_arcache,
                     m_axi_arprot, m_axi_aruser);
        end
    endtask

    task automatic test_single();
        do_reset();
        s_araddr[64 +: 64] = 64'h1000;
        s_arlen[8 +: 8]    = 8'd15;
        s_arvalid          = 3'b010;
        #1;
        checks++;
        if (s_arready !== 3'b010) begin
            errors++;
            $display("FAIL single_grant s_arready=%b want 010", s_arready);
        end
        step();
        s_arvalid = '0;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h1000 ||
            m_axi_arlen !== 8'd15 || m_axi_arid !== 4'd1) begin
            errors++;
            $display("FAIL single_ar v=%b addr=%h len=%0d id=%0d want 1/1000/15/1",
                     m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid);
        end
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL single_busy idle=%b want 0", idle);
        end
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_after_hs arvalid=%b idle=%b want 0/0",
                     m_axi_arvalid, idle);
        end
        s_rready = 3'b111;
        for (int b = 0; b < 16; b++) begin
            if (b > 0) step();
            m_axi_rvalid = 1'b1;
            m_axi_rid    = 4'd1;
            m_axi_rlast  = (b == 15);
            m_axi_rdata  = {16{32'hA000_0000 + 32'(b)}};
            #1;
            checks++;
            if (s_rvalid !== 3'b010 || m_axi_rready !== 1'b1 ||
                s_rdata !== {16{32'hA000_0000 + 32'(b)}}) begin
                errors++;
                $display("FAIL single_beat%0d s_rvalid=%b rready=%b want 010/1",
                         b, s_rvalid, m_axi_rready);
            end
        end
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1 || s_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL single_idle idle=%b s_rvalid=%b want 1/000",
                     idle, s_rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [7];
        logic [3:0] exp_id [7];
        exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
        exp_id = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
        do_reset();
        s_arvalid     = 3'b111;
        m_axi_arready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) step();
            #1;
            checks++;
            if (s_arready !== exp_g[c]) begin
                errors++;
                $display("FAIL rr_grant%0d s_arready=%b want %b",
                         c, s_arready, exp_g[c]);
            end
            if (c > 0) begin
                checks++;
                if (m_axi_arvalid !== 1'b1 || m_axi_arid !== exp_id[c]) begin
                    errors++;
                    $display("FAIL rr_arid%0d v=%b id=%0d want 1/%0d",
                             c, m_axi_arvalid, m_axi_arid, exp_id[c]);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        s_arvalid = 3'b111;
        #1;
        checks++;
        if (s_arready !== 3'b001) begin
            errors++;
            $display("FAIL stall_first s_arready=%b want 001", s_arready);
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            #1;
            checks++;
            if (s_arready !== 3'b000 || m_axi_arvalid !== 1'b1 ||
                m_axi_araddr !== 64'h1000 || m_axi_arlen !== 8'd1 ||
                m_axi_arid !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold%0d rdy=%b v=%b addr=%h len=%0d id=%0d",
                         c, s_arready, m_axi_arvalid, m_axi_araddr,
                         m_axi_arlen, m_axi_arid);
            end
        end
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if (s_arready !== 3'b010) begin
            errors++;
            $display("FAIL stall_release s_arready=%b want 010", s_arready);
        end
        step();
        #1;
        checks++;
        if (m_axi_arid !== 4'd1 || m_axi_araddr !== 64'h2000) begin
            errors++;
            $display("FAIL stall_next id=%0d addr=%h want 1/2000",
                     m_axi_arid, m_axi_araddr);
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        s_arvalid     = 3'b001;
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if (s_arready !== 3'b001) begin
            errors++;
            $display("FAIL outst_ar1 s_arready=%b want 001", s_arready);
        end
        step();
        #1;
        checks++;
        if (s_arready !== 3'b001) begin
            errors++;
            $display("FAIL outst_ar2 s_arready=%b want 001", s_arready);
        end
        step();
        #1;
        checks++;
        if (s_arready !== 3'b000) begin
            errors++;
            $display("FAIL outst_ar3_stall s_arready=%b want 000", s_arready);
        end
        step();
        #1;
        checks++;
        if (s_arready !== 3'b000 || idle !== 1'b0) begin
            errors++;
            $display("FAIL outst_full s_arready=%b idle=%b want 000/0",
                     s_arready, idle);
        end
        s_rready     = 3'b001;
        m_axi_rvalid = 1'b1;
        m_axi_rid    = 4'd0;
        m_axi_rlast  = 1'b1;
        #1;
        checks++;
        if (m_axi_rready !== 1'b1 || s_rvalid !== 3'b001) begin
            errors++;
            $display("FAIL outst_rlast rready=%b s_rvalid=%b want 1/001",
                     m_axi_rready, s_rvalid);
        end
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        checks++;
        if (s_arready !== 3'b001) begin
            errors++;
            $display("FAIL outst_ar3_go s_arready=%b want 001", s_arready);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] ids [4];
        logic       exp_rdy [4];
        logic [2:0] exp_v [4];
        ids     = '{4'd0, 4'd2, 4'd0, 4'd2};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_v   = '{3'b001, 3'b100, 3'b001, 3'b100};
        do_reset();
        s_rready = 3'b011;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) step();
            m_axi_rvalid = 1'b1;
            m_axi_rid    = ids[b];
            m_axi_rlast  = 1'b0;
            #1;
            checks++;
            if (m_axi_rready !== exp_rdy[b] || s_rvalid !== exp_v[b]) begin
                errors++;
                $display("FAIL ilv_beat%0d rready=%b s_rvalid=%b want %b/%b",
                         b, m_axi_rready, s_rvalid, exp_rdy[b], exp_v[b]);
            end
        end
        step();
        m_axi_rvalid = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ilv_noerr err=%b want 0", err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        m_axi_rvalid = 1'b1;
        m_axi_rid    = 4'd7;
        #1;
        checks++;
        if (m_axi_rready !== 1'b1 || s_rvalid !== 3'b000 || err !== 1'b0) begin
            errors++;
            $display("FAIL badid_beat rready=%b s_rvalid=%b err=%b want 1/000/0",
                     m_axi_rready, s_rvalid, err);
        end
        step();
        m_axi_rvalid = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL badid_err err=%b want 1", err);
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b want 1", err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared err=%b want 0", err);
        end
        s_rready     = 3'b001;
        m_axi_rvalid = 1'b1;
        m_axi_rid    = 4'd0;
        m_axi_rresp  = 2'b10;
        #1;
        checks++;
        if (s_rvalid !== 3'b001 || s_rresp !== 2'b10 ||
            m_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL slverr_deliver s_rvalid=%b resp=%b rready=%b",
                     s_rvalid, s_rresp, m_axi_rready);
        end
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL slverr_err err=%b want 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_outstanding();
        test_interleave();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
